// File: rtl/ctrl_cfg_arb_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_cfg_arb_pkg
// Shared definitions for the control-packet configuration chain arbiter:
// FSM state encoding, one-hot grant encodings and the AXIS widths used by
// the configuration chain (bit-cfg -> TCAM-cfg -> offset-byte BRAM-cfg).
// ---------------------------------------------------------------------------
package ctrl_cfg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    localparam int AXIS_DATA_W  = 256;
    localparam int AXIS_TUSER_W = 128;
    localparam int AXIS_TKEEP_W = AXIS_DATA_W / 8;

endpackage

// File: rtl/ctrl_cfg_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker, purely combinational.
//   req[1:0]  : request per source (bit 0 = source 0)
//   rr_last   : source served last (0 = source 0, 1 = source 1)
//   grant[1:0]: one-hot winner, GRANT_NONE when nobody requests
// On a tie the source that was not served last wins.
// ---------------------------------------------------------------------------
module rr_arb2
    import ctrl_cfg_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] grant
);

    always_comb begin
        grant = GRANT_NONE;
        if (req == 2'b11) begin
            grant = rr_last ? GRANT_S0 : GRANT_S1;
        end else if (req[0]) begin
            grant = GRANT_S0;
        end else if (req[1]) begin
            grant = GRANT_S1;
        end
    end

endmodule

// File: rtl/ctrl_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// ctrl_cfg_arbiter
// Shares the control-packet configuration chain between two AXI-Stream
// sources. Whole packets are forwarded with per-packet round-robin
// arbitration; the chain has no tready, so backpressure is absorbed on the
// source side. Packets are never interleaved, are truncated at MAX_BEATS
// beats, and are separated by at least IDLE_GAP idle cycles.
//
// Ports
//   axis_clk, aresetn         : clock, async active-low reset
//   s0_axis_* / s1_axis_*     : source beats (tdata/tuser/tkeep/tvalid/tlast)
//   s0/s1_axis_tready         : registered ready, decoded from state only
//   ctrl_m_axis_*             : beats towards the configuration chain
//   o_grant                   : one-hot current owner, 0 when none
//   o_busy                    : high whenever the FSM is not IDLE
//   o_err_len                 : one-cycle pulse on MAX_BEATS truncation
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; pick a winner, register grant (no beat accepted)
// FWD   | owner's beats forwarded with one cycle of latency
// DRAIN | packet truncated; owner's remaining beats accepted and dropped
// GAP   | enforced idle spacing before the next arbitration
// ---------------------------------------------------------------------------
module ctrl_cfg_arbiter
    import ctrl_cfg_arb_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = AXIS_DATA_W,
    parameter int C_AXIS_TUSER_WIDTH = AXIS_TUSER_W,
    parameter int MAX_BEATS          = 64,
    parameter int BEAT_CNT_W         = 7,
    parameter int IDLE_GAP           = 2
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s0_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s0_axis_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s0_axis_tkeep,
    input  logic                              s0_axis_tvalid,
    input  logic                              s0_axis_tlast,
    output logic                              s0_axis_tready,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s1_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s1_axis_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s1_axis_tkeep,
    input  logic                              s1_axis_tvalid,
    input  logic                              s1_axis_tlast,
    output logic                              s1_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]      ctrl_m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     ctrl_m_axis_tuser,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    ctrl_m_axis_tkeep,
    output logic                              ctrl_m_axis_tvalid,
    output logic                              ctrl_m_axis_tlast,

    output logic [1:0]                        o_grant,
    output logic                              o_busy,
    output logic                              o_err_len
);

    // GAP is a down-counter loaded with IDLE_GAP-1 and left at terminal count 0.
    localparam int         GAP_W    = (IDLE_GAP > 2) ? $clog2(IDLE_GAP) : 1;
    localparam int         GAP_LOAD = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
    localparam arb_state_t POST_PKT = (IDLE_GAP == 0) ? IDLE : GAP;

    arb_state_t              state;
    logic [1:0]              grant_q;
    logic [1:0]              tready_q;
    logic                    rr_last;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [1:0]              rr_grant;

    logic                            owner;
    logic                            hs;
    logic                            sel_last;
    logic [C_AXIS_DATA_WIDTH-1:0]    sel_tdata;
    logic [C_AXIS_TUSER_WIDTH-1:0]   sel_tuser;
    logic [C_AXIS_DATA_WIDTH/8-1:0]  sel_tkeep;

    rr_arb2 u_rr_arb2 (
        .req     ({s1_axis_tvalid, s0_axis_tvalid}),
        .rr_last (rr_last),
        .grant   (rr_grant)
    );

    // Ready is only ever set for the owner, so a handshake implies the owner.
    assign owner     = grant_q[1];
    assign hs        = |(tready_q & {s1_axis_tvalid, s0_axis_tvalid});
    assign sel_last  = owner ? s1_axis_tlast  : s0_axis_tlast;
    assign sel_tdata = owner ? s1_axis_tdata  : s0_axis_tdata;
    assign sel_tuser = owner ? s1_axis_tuser  : s0_axis_tuser;
    assign sel_tkeep = owner ? s1_axis_tkeep  : s0_axis_tkeep;

    assign s0_axis_tready = tready_q[0];
    assign s1_axis_tready = tready_q[1];
    assign o_grant        = grant_q;
    assign o_busy         = (state != IDLE);

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= IDLE;
            grant_q            <= GRANT_NONE;
            tready_q           <= 2'b00;
            rr_last            <= 1'b1;
            beat_cnt           <= '0;
            gap_cnt            <= '0;
            ctrl_m_axis_tdata  <= '0;
            ctrl_m_axis_tuser  <= '0;
            ctrl_m_axis_tkeep  <= '0;
            ctrl_m_axis_tvalid <= 1'b0;
            ctrl_m_axis_tlast  <= 1'b0;
            o_err_len          <= 1'b0;
        end else begin
            o_err_len <= 1'b0;
            case (state)
                IDLE: begin
                    ctrl_m_axis_tvalid <= 1'b0;
                    ctrl_m_axis_tlast  <= 1'b0;
                    if (rr_grant != GRANT_NONE) begin
                        state    <= FWD;
                        grant_q  <= rr_grant;
                        tready_q <= rr_grant;
                    end
                end
                FWD: begin
                    if (hs) begin
                        ctrl_m_axis_tvalid <= 1'b1;
                        ctrl_m_axis_tdata  <= sel_tdata;
                        ctrl_m_axis_tuser  <= sel_tuser;
                        ctrl_m_axis_tkeep  <= sel_tkeep;
                        if (sel_last) begin
                            ctrl_m_axis_tlast <= 1'b1;
                            rr_last           <= owner;
                            state             <= POST_PKT;
                            gap_cnt           <= GAP_W'(GAP_LOAD);
                            beat_cnt          <= '0;
                            grant_q           <= GRANT_NONE;
                            tready_q          <= 2'b00;
                        end else if (beat_cnt == BEAT_CNT_W'(MAX_BEATS - 1)) begin
                            // Cut the packet here; rest of it is swallowed in DRAIN.
                            ctrl_m_axis_tlast <= 1'b1;
                            o_err_len         <= 1'b1;
                            state             <= DRAIN;
                            beat_cnt          <= '0;
                        end else begin
                            ctrl_m_axis_tlast <= 1'b0;
                            beat_cnt          <= beat_cnt + 1'b1;
                        end
                    end else begin
                        ctrl_m_axis_tvalid <= 1'b0;
                        ctrl_m_axis_tlast  <= 1'b0;
                    end
                end
                DRAIN: begin
                    ctrl_m_axis_tvalid <= 1'b0;
                    ctrl_m_axis_tlast  <= 1'b0;
                    if (hs && sel_last) begin
                        rr_last  <= owner;
                        state    <= POST_PKT;
                        gap_cnt  <= GAP_W'(GAP_LOAD);
                        beat_cnt <= '0;
                        grant_q  <= GRANT_NONE;
                        tready_q <= 2'b00;
                    end
                end
                GAP: begin
                    ctrl_m_axis_tvalid <= 1'b0;
                    ctrl_m_axis_tlast  <= 1'b0;
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ctrl_cfg_arbiter
// Directed bench for ctrl_cfg_arbiter built with MAX_BEATS=4, IDLE_GAP=2.
// A monitor records every output beat and every source handshake with a
// negedge cycle stamp; each test task drives packets and compares the
// recorded stream against hand-computed expectations.
// Data tagging: tdata[31:28] = source, tdata[15:8] = packet, [7:0] = beat.
// ---------------------------------------------------------------------------
module tb_ctrl_cfg_arbiter;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    logic           axis_clk = 1'b0;
    logic           aresetn  = 1'b0;
    logic [DW-1:0]  s0_axis_tdata = '0, s1_axis_tdata = '0;
    logic [UW-1:0]  s0_axis_tuser = '0, s1_axis_tuser = '0;
    logic [KW-1:0]  s0_axis_tkeep = '1, s1_axis_tkeep = '1;
    logic           s0_axis_tvalid = 1'b0, s1_axis_tvalid = 1'b0;
    logic           s0_axis_tlast = 1'b0, s1_axis_tlast = 1'b0;
    logic           s0_axis_tready, s1_axis_tready;
    logic [DW-1:0]  ctrl_m_axis_tdata;
    logic [UW-1:0]  ctrl_m_axis_tuser;
    logic [KW-1:0]  ctrl_m_axis_tkeep;
    logic           ctrl_m_axis_tvalid, ctrl_m_axis_tlast;
    logic [1:0]     o_grant;
    logic           o_busy, o_err_len;

    ctrl_cfg_arbiter #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .MAX_BEATS          (4),
        .BEAT_CNT_W         (3),
        .IDLE_GAP           (2)
    ) dut (
        .axis_clk           (axis_clk),
        .aresetn            (aresetn),
        .s0_axis_tdata      (s0_axis_tdata),
        .s0_axis_tuser      (s0_axis_tuser),
        .s0_axis_tkeep      (s0_axis_tkeep),
        .s0_axis_tvalid     (s0_axis_tvalid),
        .s0_axis_tlast      (s0_axis_tlast),
        .s0_axis_tready     (s0_axis_tready),
        .s1_axis_tdata      (s1_axis_tdata),
        .s1_axis_tuser      (s1_axis_tuser),
        .s1_axis_tkeep      (s1_axis_tkeep),
        .s1_axis_tvalid     (s1_axis_tvalid),
        .s1_axis_tlast      (s1_axis_tlast),
        .s1_axis_tready     (s1_axis_tready),
        .ctrl_m_axis_tdata  (ctrl_m_axis_tdata),
        .ctrl_m_axis_tuser  (ctrl_m_axis_tuser),
        .ctrl_m_axis_tkeep  (ctrl_m_axis_tkeep),
        .ctrl_m_axis_tvalid (ctrl_m_axis_tvalid),
        .ctrl_m_axis_tlast  (ctrl_m_axis_tlast),
        .o_grant            (o_grant),
        .o_busy             (o_busy),
        .o_err_len          (o_err_len)
    );

    initial forever #5 axis_clk = ~axis_clk;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic [31:0] u;
        logic        last;
        logic [1:0]  g;
    } beat_t;

    typedef struct {
        int cyc;
        int src;
    } hs_t;

    beat_t out_q[$];
    hs_t   hs_q[$];
    int    err_cnt = 0;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    // Handshakes seen here complete at the following posedge; their output
    // beat is therefore expected at the next negedge (cyc + 1).
    initial begin
        beat_t b;
        hs_t   h;
        forever begin
            @(negedge axis_clk);
            cyc = cyc + 1;
            if (ctrl_m_axis_tvalid) begin
                b.cyc  = cyc;
                b.d    = ctrl_m_axis_tdata[31:0];
                b.u    = ctrl_m_axis_tuser[31:0];
                b.last = ctrl_m_axis_tlast;
                b.g    = o_grant;
                out_q.push_back(b);
            end
            if (s0_axis_tvalid && s0_axis_tready) begin
                h.cyc = cyc; h.src = 0; hs_q.push_back(h);
            end
            if (s1_axis_tvalid && s1_axis_tready) begin
                h.cyc = cyc; h.src = 1; hs_q.push_back(h);
            end
            if (o_err_len) err_cnt = err_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int src, input logic v, input logic [31:0] d, input logic l);
        if (src == 0) begin
            s0_axis_tvalid = v;
            s0_axis_tdata  = {224'h0, d};
            s0_axis_tuser  = {96'h0, ~d};
            s0_axis_tlast  = l;
        end else begin
            s1_axis_tvalid = v;
            s1_axis_tdata  = {224'h0, d};
            s1_axis_tuser  = {96'h0, ~d};
            s1_axis_tlast  = l;
        end
    endtask

    // Sends one packet; after beat index bubble_after-1 tvalid drops for 3 cycles.
    task automatic send_pkt(input int src, input int nbeats, input logic [31:0] base,
                            input int bubble_after);
        int t;
        bit ok;
        for (int b = 0; b < nbeats; b++) begin
            drive(src, 1'b1, base + 32'(b), (b == nbeats - 1));
            t  = 0;
            ok = 1'b0;
            while (!ok && t < 300) begin
                @(negedge axis_clk);
                t++;
                if ((src == 0) ? s0_axis_tready : s1_axis_tready) ok = 1'b1;
            end
            if (!ok) begin
                n_checks++;
                $display("FAIL send_timeout src%0d beat %0d: no tready within %0d cycles", src, b, t);
                drive(src, 1'b0, 32'h0, 1'b0);
                return;
            end
            @(posedge axis_clk);
            #1;
            if (b == bubble_after - 1 && b != nbeats - 1) begin
                drive(src, 1'b0, 32'h0, 1'b0);
                repeat (3) @(posedge axis_clk);
                #1;
            end
        end
        drive(src, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (o_busy && t < 300) begin
            @(negedge axis_clk);
            t++;
        end
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL %s_idle busy=%b want 0", name, o_busy);
        else n_pass++;
    endtask

    task automatic clear_logs();
        @(posedge axis_clk);
        #1;
        out_q.delete();
        hs_q.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge axis_clk);
        #1;
        n_checks++;
        if ({o_grant, o_busy, o_err_len, ctrl_m_axis_tvalid, s0_axis_tready, s1_axis_tready} !== 7'b0)
            $display("FAIL reset_during got grant=%b busy=%b err=%b mv=%b r0=%b r1=%b want all 0",
                     o_grant, o_busy, o_err_len, ctrl_m_axis_tvalid, s0_axis_tready, s1_axis_tready);
        else n_pass++;
        @(negedge axis_clk);
        aresetn = 1'b1;
        repeat (2) @(negedge axis_clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_grant !== 2'b00) $display("FAIL reset_idle busy=%b grant=%b want 0 00", o_busy, o_grant);
        else n_pass++;
        n_checks++;
        if (ctrl_m_axis_tdata !== '0 || ctrl_m_axis_tvalid !== 1'b0 || ctrl_m_axis_tlast !== 1'b0)
            $display("FAIL reset_m_axis tvalid=%b tlast=%b tdata=%h want 0", ctrl_m_axis_tvalid, ctrl_m_axis_tlast, ctrl_m_axis_tdata[31:0]);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [31:0] exp_d [5] = '{32'h0000_0100, 32'h0000_0101, 32'h0000_0102, 32'h1000_0200, 32'h1000_0201};
        logic        exp_l [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        clear_logs();
        fork
            send_pkt(0, 3, 32'h0000_0100, 0);
            send_pkt(1, 2, 32'h1000_0200, 0);
        join
        wait_idle("contention");
        n_checks++;
        if (out_q.size() !== 5) $display("FAIL contention_count got %0d want 5", out_q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            n_checks++;
            if ({out_q[i].last, out_q[i].d} !== {exp_l[i], exp_d[i]})
                $display("FAIL contention_beat%0d got d=%h last=%b want d=%h last=%b", i, out_q[i].d, out_q[i].last, exp_d[i], exp_l[i]);
            else n_pass++;
        end
        if (out_q.size() == 5) begin
            n_checks++;
            if (out_q[3].cyc - out_q[2].cyc !== 4) $display("FAIL contention_gap got %0d want 4", out_q[3].cyc - out_q[2].cyc);
            else n_pass++;
            n_checks++;
            if (out_q[2].cyc - out_q[0].cyc !== 2) $display("FAIL contention_s0_consecutive got %0d want 2", out_q[2].cyc - out_q[0].cyc);
            else n_pass++;
        end
    endtask

    task automatic test_fairness();
        logic [31:0] exp_d;
        logic        exp_l;
        int          k;
        clear_logs();
        fork
            for (int p = 0; p < 4; p++) send_pkt(0, 2, 32'h0000_0000 | (32'(p) << 8), 0);
            for (int p = 0; p < 4; p++) send_pkt(1, 2, 32'h1000_0000 | (32'(p) << 8), 0);
        join
        wait_idle("fairness");
        n_checks++;
        if (out_q.size() !== 16) $display("FAIL fairness_count got %0d want 16", out_q.size());
        else n_pass++;
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            k     = i / 2;
            exp_d = (32'(k % 2) << 28) | (32'(k / 2) << 8) | 32'(i % 2);
            exp_l = (i % 2 == 1);
            n_checks++;
            if ({out_q[i].last, out_q[i].d} !== {exp_l, exp_d})
                $display("FAIL fairness_beat%0d got d=%h last=%b want d=%h last=%b", i, out_q[i].d, out_q[i].last, exp_d, exp_l);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        clear_logs();
        send_pkt(0, 3, 32'h0000_0700, 0);
        wait_idle("single");
        n_checks++;
        if (out_q.size() !== 3 || hs_q.size() !== 3)
            $display("FAIL single_count got out=%0d hs=%0d want 3 3", out_q.size(), hs_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < out_q.size() && i < hs_q.size(); i++) begin
            n_checks++;
            if ({out_q[i].last, out_q[i].d} !== {(i == 2), 32'h0000_0700 + 32'(i)})
                $display("FAIL single_beat%0d got d=%h last=%b want d=%h last=%b", i, out_q[i].d, out_q[i].last, 32'h0000_0700 + 32'(i), (i == 2));
            else n_pass++;
            n_checks++;
            if (out_q[i].cyc !== hs_q[i].cyc + 1)
                $display("FAIL single_latency%0d got cyc %0d want %0d", i, out_q[i].cyc, hs_q[i].cyc + 1);
            else n_pass++;
        end
        if (out_q.size() == 3) begin
            n_checks++;
            if (out_q[0].g !== 2'b01 || out_q[1].g !== 2'b01)
                $display("FAIL single_grant got %b %b want 01 01", out_q[0].g, out_q[1].g);
            else n_pass++;
            n_checks++;
            if (out_q[0].u !== ~32'h0000_0700) $display("FAIL single_tuser got %h want %h", out_q[0].u, ~32'h0000_0700);
            else n_pass++;
        end
    endtask

    task automatic test_truncation();
        clear_logs();
        send_pkt(1, 6, 32'h1000_0500, 0);
        wait_idle("trunc");
        n_checks++;
        if (out_q.size() !== 4) $display("FAIL trunc_count got %0d want 4", out_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            n_checks++;
            if ({out_q[i].last, out_q[i].d} !== {(i == 3), 32'h1000_0500 + 32'(i)})
                $display("FAIL trunc_beat%0d got d=%h last=%b want d=%h last=%b", i, out_q[i].d, out_q[i].last, 32'h1000_0500 + 32'(i), (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (err_cnt !== 1) $display("FAIL trunc_err_pulses got %0d want 1", err_cnt);
        else n_pass++;
        n_checks++;
        if (hs_q.size() !== 6) $display("FAIL trunc_accepted got %0d want 6", hs_q.size());
        else n_pass++;
    endtask

    task automatic test_bubbles();
        clear_logs();
        send_pkt(0, 4, 32'h0000_0600, 2);
        wait_idle("bubble");
        n_checks++;
        if (out_q.size() !== 4) $display("FAIL bubble_count got %0d want 4", out_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            n_checks++;
            if ({out_q[i].last, out_q[i].d} !== {(i == 3), 32'h0000_0600 + 32'(i)})
                $display("FAIL bubble_beat%0d got d=%h last=%b want d=%h last=%b", i, out_q[i].d, out_q[i].last, 32'h0000_0600 + 32'(i), (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (err_cnt !== 0) $display("FAIL bubble_err_pulses got %0d want 0", err_cnt);
        else n_pass++;
        if (out_q.size() == 4) begin
            n_checks++;
            if (out_q[2].cyc - out_q[1].cyc !== 4) $display("FAIL bubble_spacing got %0d want 4", out_q[2].cyc - out_q[1].cyc);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int  t;
        bit  ok;
        clear_logs();
        drive(0, 1'b1, 32'h0000_0800, 1'b0);
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 50) begin
            @(negedge axis_clk);
            t++;
            if (s0_axis_tready) ok = 1'b1;
        end
        n_checks++;
        if (!ok) $display("FAIL rstmid_grant s0_tready=%b want 1", s0_axis_tready);
        else n_pass++;
        @(posedge axis_clk);
        #1;
        drive(0, 1'b1, 32'h0000_0801, 1'b0);
        @(posedge axis_clk);
        #2;
        n_checks++;
        if (ctrl_m_axis_tvalid !== 1'b1 || ctrl_m_axis_tdata[31:0] !== 32'h0000_0801)
            $display("FAIL rstmid_beat2 got v=%b d=%h want 1 00000801", ctrl_m_axis_tvalid, ctrl_m_axis_tdata[31:0]);
        else n_pass++;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({o_grant, o_busy, o_err_len, ctrl_m_axis_tvalid, ctrl_m_axis_tlast, s0_axis_tready, s1_axis_tready} !== 8'b0
            || ctrl_m_axis_tdata !== '0)
            $display("FAIL rstmid_clear got grant=%b busy=%b mv=%b ml=%b r0=%b d=%h want all 0",
                     o_grant, o_busy, ctrl_m_axis_tvalid, ctrl_m_axis_tlast, s0_axis_tready, ctrl_m_axis_tdata[31:0]);
        else n_pass++;
        drive(0, 1'b0, 32'h0, 1'b0);
        @(negedge axis_clk);
        aresetn = 1'b1;
        clear_logs();
        // s0 was served last before reset, but reset restores s0 priority on a tie.
        fork
            send_pkt(1, 1, 32'h1000_0900, 0);
            send_pkt(0, 1, 32'h0000_0900, 0);
        join
        wait_idle("rstmid");
        n_checks++;
        if (out_q.size() !== 2) $display("FAIL rstmid_count got %0d want 2", out_q.size());
        else n_pass++;
        if (out_q.size() == 2) begin
            n_checks++;
            if (out_q[0].d !== 32'h0000_0900 || out_q[1].d !== 32'h1000_0900)
                $display("FAIL rstmid_order got %h %h want 00000900 10000900", out_q[0].d, out_q[1].d);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_fairness();
        test_single();
        test_truncation();
        test_bubbles();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_cfg_arbiter.md
Name: ctrl_cfg_arbiter

Overview:
- Shares the single control-packet configuration chain (bit-cfg -> TCAM-cfg -> offset-byte BRAM-cfg) between two AXI-Stream control sources, e.g. host path and local management path.
- Arbitrates per packet with round-robin priority and forwards whole packets onto the chain.
- The chain has no tready, so the arbiter absorbs backpressure on the source side and guarantees no interleaving, a bounded packet length and a minimum inter-packet gap.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width.
- C_AXIS_TUSER_WIDTH, 128, tuser width.
- MAX_BEATS, 64, maximum beats per control packet before truncation (>=1).
- BEAT_CNT_W, 7, beat counter width; must satisfy 2^BEAT_CNT_W > MAX_BEATS.
- IDLE_GAP, 2, idle cycles forced between consecutive output packets (0 allowed).

Ports:
- axis_clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s0_axis_tdata/tuser/tkeep  in  256/128/32  source 0 beat.
- s0_axis_tvalid/tlast  in  1/1  source 0 valid/last.
- s0_axis_tready  out  1  source 0 ready.
- s1_axis_tdata/tuser/tkeep/tvalid/tlast  in  same widths  source 1.
- s1_axis_tready  out  1  source 1 ready.
- ctrl_m_axis_tdata/tuser/tkeep  out  256/128/32  to configuration chain.
- ctrl_m_axis_tvalid/tlast  out  1/1  to configuration chain.
- o_grant  out  2  one-hot current owner; 0 when no owner.
- o_busy  out  1  high in any state other than IDLE.
- o_err_len  out  1  one-cycle pulse when a packet is truncated at MAX_BEATS.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, all outputs 0, rr_last=1 so source 0 wins first, beat_cnt=0, gap_cnt=0.
- States: IDLE, FWD, DRAIN, GAP.
- IDLE:
  - Both tready=0.
  - If only one source has tvalid, grant it.
  - If both have tvalid, grant the source that is not rr_last.
  - o_grant is registered and goes to FWD the next cycle; no beat is accepted in the grant cycle.
- FWD:
  - Granted tready=1; the other source tready=0.
  - On handshake, register the beat onto ctrl_m_* (1-cycle latency, ctrl_m_axis_tvalid=1) and increment beat_cnt.
  - Without a handshake, ctrl_m_axis_tvalid=0 and beat_cnt holds; source bubbles are legal.
  - On a handshake with tlast: set rr_last=owner and go to GAP.
  - On the MAX_BEATS-th handshake without tlast: output that beat with tlast forced to 1, pulse o_err_len and go to DRAIN.
- DRAIN:
  - Granted tready=1, ctrl_m_axis_tvalid=0; beats are discarded.
  - On a tlast handshake: set rr_last=owner and go to GAP.
- GAP:
  - Both tready=0, ctrl_m_axis_tvalid=0, o_grant=0.
  - Count IDLE_GAP cycles, then go to IDLE.
  - If IDLE_GAP=0, FWD/DRAIN go straight to IDLE.
  - Leaving FWD/DRAIN clears beat_cnt.
- ctrl_m_axis_tdata/tuser/tkeep hold their last value when tvalid=0; they are don't-care to consumers.
- tready is a registered state decode and never combinationally depends on tvalid.
- Back-to-back packets from one source:
  - Minimum spacing is IDLE_GAP+1 cycles between the last beat and the next first output beat (GAP + IDLE grant cycle).
  - If the other source is waiting, it wins.
- Single-beat packet (tlast on first beat): forwarded normally; beat_cnt limit is not involved.
- MAX_BEATS=1: every non-tlast first beat is truncated.
- Reset mid-packet: outputs clear immediately. Downstream may see a packet without tlast. Config modules must tolerate this; it is not retried.

Decomposition:
- Package ctrl_cfg_arb_pkg holds:
  - state encoding (IDLE=2'd0, FWD=2'd1, DRAIN=2'd2, GAP=2'd3);
  - grant encodings;
  - the AXIS width localparams shared with the config chain.
- Sub-module rr_arb2 is natural: 2-way round-robin picker taking req[1:0] and rr_last and returning a one-hot grant. It is purely combinational; the main FSM registers its result.

Test Plan:
- Single source: s0 sends 3 beats (tdata=A,B,C, tlast on C) -> ctrl_m carries A,B,C on consecutive cycles, 1 cycle after each handshake; tlast only on C; o_grant=01 during FWD.
- Contention: s0 and s1 both assert tvalid in the same IDLE cycle after reset -> s0 packet forwarded first, then exactly IDLE_GAP=2 idle cycles plus 1 grant cycle, then the s1 packet; no interleaved beats.
- Fairness: s0 and s1 each stream 4 back-to-back 2-beat packets -> output packet order s0,s1,s0,s1,...
- Truncation: MAX_BEATS=4, s1 sends 6 beats -> beats 1-4 are output with tlast on beat 4; o_err_len pulses once; beats 5-6 are accepted and dropped; then GAP.
- Source bubbles: s0 deasserts tvalid for 3 cycles mid-packet -> ctrl_m_axis_tvalid=0 for those cycles and beat_cnt holds; no truncation at MAX_BEATS=64 for a 10-beat packet.
- Reset mid-packet: assert aresetn=0 on beat 2 of 5 -> all outputs 0 asynchronously; after release, a new s1 request is granted (rr_last=1 means s0 still takes priority on a tie).
